// File: rtl/pat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pat_pkg
// Description : Shared width constants and drain state type for pattern_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pat_pkg;

    localparam int C_BUFP_WIDTH   = 3;
    localparam int C_FIELDP_WIDTH = 5;
    localparam int C_BUFFER_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/commit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : commit_fifo
// Description : Synchronous FIFO of committed buffer indices, depth 2^BUFP_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_fifo #(
    parameter int BUFP_WIDTH = pat_pkg::C_BUFP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [BUFP_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [BUFP_WIDTH-1:0] o_pop_data,
    output logic                  o_empty
);

    localparam int C_DEPTH = 2**BUFP_WIDTH;

    logic [BUFP_WIDTH-1:0] r_mem [C_DEPTH];
    logic [BUFP_WIDTH-1:0] r_wr_ptr;
    logic [BUFP_WIDTH-1:0] r_rd_ptr;
    logic [BUFP_WIDTH:0]   r_count;
    logic                  w_do_pop;

    // Each buffer holds at most one entry, so a push never meets a full FIFO.
    assign w_do_pop   = i_pop && !o_empty;
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_buffer
// Description : Field buffer bank beside the pat core; committed buffers are
//               drained in order over valid/ready. Option: PATBUF_CLEAR_EN
//               zeroes each field as it drains.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_buffer
    import pat_pkg::*;
#(
    parameter int BUFP_WIDTH   = C_BUFP_WIDTH,
    parameter int FIELDP_WIDTH = C_FIELDP_WIDTH,
    parameter int BUFFER_WIDTH = C_BUFFER_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BUFP_WIDTH-1:0]     bufp,
    input  logic [FIELDP_WIDTH-1:0]   fieldp,
    output logic [BUFFER_WIDTH-1:0]   field_in,
    input  logic [FIELDP_WIDTH-1:0]   fieldwp,
    input  logic [BUFFER_WIDTH-1:0]   field_out,
    input  logic                      field_we,
    input  logic                      commit,
    output logic [2**BUFP_WIDTH-1:0]  busy,
    output logic                      field_wr_drop,
    output logic [BUFFER_WIDTH-1:0]   out_data,
    output logic [BUFP_WIDTH-1:0]     out_buf,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int C_NBUF   = 2**BUFP_WIDTH;
    localparam int C_ADDR_W = BUFP_WIDTH + FIELDP_WIDTH;
`ifdef PATBUF_CLEAR_EN
    localparam bit C_CLEAR_EN = 1'b1;
`else
    localparam bit C_CLEAR_EN = 1'b0;
`endif

    logic [BUFFER_WIDTH-1:0] r_mem [2**C_ADDR_W];
    drain_state_t            r_state;
    drain_state_t            w_state_nxt;
    logic [BUFP_WIDTH-1:0]   r_out_buf;
    logic [FIELDP_WIDTH-1:0] r_cnt;
    logic [C_NBUF-1:0]       r_busy;
    logic                    r_drop;
    logic [C_NBUF-1:0]       w_busy_set;
    logic [C_NBUF-1:0]       w_busy_clr;
    logic                    w_sel_busy;
    logic                    w_wr_ok;
    logic                    w_commit_ok;
    logic                    w_pop;
    logic                    w_hs;
    logic                    w_done;
    logic                    w_cnt_last;
    logic [BUFP_WIDTH-1:0]   w_fifo_head;
    logic                    w_fifo_empty;

    assign w_sel_busy  = r_busy[bufp];
    assign w_wr_ok     = field_we && !w_sel_busy;
    assign w_commit_ok = commit && !w_sel_busy;
    assign w_cnt_last  = &r_cnt;
    assign w_busy_set  = w_commit_ok ? ({{(C_NBUF-1){1'b0}}, 1'b1} << bufp)      : '0;
    assign w_busy_clr  = w_done      ? ({{(C_NBUF-1){1'b0}}, 1'b1} << r_out_buf) : '0;

    commit_fifo #(
        .BUFP_WIDTH (BUFP_WIDTH)
    ) u_commit_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_commit_ok),
        .i_push_data (bufp),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hs        = 1'b0;
        w_done      = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                w_hs      = out_ready;
                if (out_ready && w_cnt_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_buf <= '0;
            r_cnt     <= '0;
            r_busy    <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= (field_we || commit) && w_sel_busy;
            r_busy <= (r_busy | w_busy_set) & ~w_busy_clr;
            if (w_pop) begin
                r_out_buf <= w_fifo_head;
                r_cnt     <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Core writes only reach unlocked buffers, so they never collide with the drain-side clear.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[{bufp, fieldwp}] <= field_out;
        end
        if (C_CLEAR_EN && w_hs && !reset) begin
            r_mem[{r_out_buf, r_cnt}] <= '0;
        end
    end

    assign field_in      = r_mem[{bufp, fieldp}];
    assign out_data      = out_valid ? r_mem[{r_out_buf, r_cnt}] : '0;
    assign out_last      = out_valid && w_cnt_last;
    assign out_buf       = r_out_buf;
    assign busy          = r_busy;
    assign field_wr_drop = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pattern_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_buffer
// Description : Randomized scoreboard bench for pattern_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_buffer;
    import pat_pkg::*;

    localparam int BW = C_BUFP_WIDTH;
    localparam int FW = C_FIELDP_WIDTH;
    localparam int DW = C_BUFFER_WIDTH;
    localparam int NB = 1 << BW;
    localparam int NF = 1 << FW;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [BW-1:0] bufp      = '0;
    logic [FW-1:0] fieldp    = '0;
    logic [FW-1:0] fieldwp   = '0;
    logic [DW-1:0] field_out = '0;
    logic          field_we  = 1'b0;
    logic          commit    = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] field_in;
    logic [NB-1:0] busy;
    logic          field_wr_drop;
    logic [DW-1:0] out_data;
    logic [BW-1:0] out_buf;
    logic          out_last;
    logic          out_valid;

    always #5 clk = ~clk;

    pattern_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .bufp          (bufp),
        .fieldp        (fieldp),
        .field_in      (field_in),
        .fieldwp       (fieldwp),
        .field_out     (field_out),
        .field_we      (field_we),
        .commit        (commit),
        .busy          (busy),
        .field_wr_drop (field_wr_drop),
        .out_data      (out_data),
        .out_buf       (out_buf),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    typedef struct {
        int            b;
        int            f;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [NB*NF];
    bit            m_vld [NB*NF];
    logic [NB-1:0] m_busy     = '0;
    logic          exp_drop   = 1'b0;
    bit            clr_pend   = 1'b0;
    int            clr_buf    = 0;
    bit            after_last = 1'b0;
    int            n_cmp      = 0;
    int            n_bad      = 0;

    function automatic int idx(input int b, input int f);
        return b * NF + f;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // One clock: check at the falling edge, then apply the model for the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            chk("field_wr_drop", {63'd0, field_wr_drop}, {63'd0, exp_drop});
            chk("busy", 64'(busy), 64'(m_busy));
            if (!m_busy[bufp] && m_vld[idx(int'(bufp), int'(fieldp))])
                chk("field_in", 64'(field_in), 64'(m_mem[idx(int'(bufp), int'(fieldp))]));
        end
        @(posedge clk);
        if (reset) begin
            m_busy   = '0;
            exp_q.delete();
            clr_pend = 1'b0;
            exp_drop = 1'b0;
        end else begin
            exp_drop = (field_we || commit) && m_busy[bufp];
            if (field_we && !m_busy[bufp]) begin
                m_mem[idx(int'(bufp), int'(fieldwp))] = field_out;
                m_vld[idx(int'(bufp), int'(fieldwp))] = 1'b1;
            end
            if (commit && !m_busy[bufp]) begin
                m_busy[bufp] = 1'b1;
                for (int f = 0; f < NF; f++)
                    exp_q.push_back('{int'(bufp), f, m_mem[idx(int'(bufp), f)]});
            end
            if (clr_pend) begin
                m_busy[clr_buf] = 1'b0;
                clr_pend        = 1'b0;
            end
        end
        #1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || clr_pend) && n < limit) begin
            tick();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || clr_pend) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d fields left, required 0", exp_q.size());
        end
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a field.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            after_last = 1'b0;
        end else if (after_last) begin
            chk("bubble_valid", {63'd0, out_valid}, 64'd0);
            after_last = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_extra: got buf %0d data %0h, required no field", out_buf, out_data);
            end else begin
                e = exp_q[0];
                chk("out_buf", 64'(out_buf), 64'(e.b));
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_last", {63'd0, out_last}, {63'd0, (e.f == NF - 1)});
                if (out_ready) begin
                    exp_q.delete(0);
`ifdef PATBUF_CLEAR_EN
                    m_mem[idx(e.b, e.f)] = '0;
`endif
                    if (e.f == NF - 1) begin
                        clr_pend   = 1'b1;
                        clr_buf    = e.b;
                        after_last = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_out_buf", 64'(out_buf), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_drop", {63'd0, field_wr_drop}, 64'd0);
        reset = 1'b0;

        // Fill every buffer with random data.
        field_we = 1'b1;
        for (int a = 0; a < NB * NF; a++) begin
            bufp      = BW'(a / NF);
            fieldwp   = FW'(a % NF);
            field_out = DW'($urandom);
            tick();
        end

        // Buffer 2 gets 0x00..0x1F, then read back.
        bufp = BW'(2);
        for (int f = 0; f < NF; f++) begin
            fieldwp   = FW'(f);
            field_out = DW'(f);
            tick();
        end
        field_we = 1'b0;
        for (int f = 0; f < NF; f++) begin
            fieldp = FW'(f);
            tick();
        end

        // Commit buffer 2 and check first-valid latency.
        out_ready = 1'b1;
        commit    = 1'b1;
        tick();
        commit = 1'b0;
        chk("valid_t+1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("valid_t+2", {63'd0, out_valid}, 64'd1);
        wait_drain(100);

        // Stall mid-drain for 5 cycles.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (12) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_drain(100);

        // Commit 1, 3, then 1 again while busy.
        out_ready = 1'b0;
        commit    = 1'b1;
        bufp      = BW'(1);
        tick();
        bufp = BW'(3);
        tick();
        bufp = BW'(1);
        tick();
        commit    = 1'b0;
        out_ready = 1'b1;
        wait_drain(200);

        // Write to busy buffer 3 is dropped.
        out_ready = 1'b0;
        bufp      = BW'(3);
        commit    = 1'b1;
        tick();
        commit    = 1'b0;
        field_we  = 1'b1;
        fieldwp   = FW'(5);
        field_out = 8'hAA;
        tick();
        field_we  = 1'b0;
        out_ready = 1'b1;
        wait_drain(100);
        for (int f = 0; f < NF; f++) begin
            fieldp = FW'(f);
            tick();
        end

        // Reset asserted at field 10 of a drain.
        bufp   = BW'(1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        repeat (10) tick();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        commit    = 1'b1;
        tick();
        commit = 1'b0;
        wait_drain(100);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bufp      = BW'($urandom_range(NB - 1));
            fieldp    = FW'($urandom_range(NF - 1));
            fieldwp   = FW'($urandom_range(NF - 1));
            field_out = DW'($urandom);
            field_we  = ($urandom_range(1) == 1);
            commit    = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end
        field_we  = 1'b0;
        commit    = 1'b0;
        out_ready = 1'b1;
        wait_drain(NB * (NF + 2) + 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
